// File: rtl/uart_wb_bist.sv
// rtl/uart_wb_bist.sv - Wishbone-master loopback self-test sequencer for one 16550 uart_top
// Optional feature macro UART_BIST_TIMEOUT_EN: bounded LSR polls and the timeout_o port.
module uart_wb_bist #(
    parameter int          NUM_BYTES   = 4,
    parameter logic [15:0] DIVISOR     = 16'd2,
    parameter logic [7:0]  LCR_CFG     = 8'h1B,
    parameter int          PATTERN     = 0,
    parameter logic [7:0]  SEED        = 8'h81,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [7:0]  last_rx_o
`ifdef UART_BIST_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);
    localparam int         BCW        = $clog2(NUM_BYTES + 1);
    localparam logic [7:0] FIRST_BYTE = (PATTERN == 1 && SEED == 8'h00) ? 8'h01 : SEED;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LCR_HI    = 4'd1;
    localparam logic [3:0] ST_DL1       = 4'd2;
    localparam logic [3:0] ST_DL2       = 4'd3;
    localparam logic [3:0] ST_LCR_LO    = 4'd4;
    localparam logic [3:0] ST_FCR       = 4'd5;
    localparam logic [3:0] ST_MCR       = 4'd6;
    localparam logic [3:0] ST_POLL_THRE = 4'd7;
    localparam logic [3:0] ST_WR_THR    = 4'd8;
    localparam logic [3:0] ST_POLL_DR   = 4'd9;
    localparam logic [3:0] ST_RD_RBR    = 4'd10;
    localparam logic [3:0] ST_CHECK     = 4'd11;
    localparam logic [3:0] ST_RESTORE   = 4'd12;
    localparam logic [3:0] ST_DONE      = 4'd13;
    localparam logic [3:0] ST_GAP       = 4'd14;

    if (NUM_BYTES < 1 || NUM_BYTES > 65535 || PATTERN < 0 || PATTERN > 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_wb_bist: parameter out of range");
    end

    logic [3:0]     state_q, state_d, ret_q, ret_d;
    logic           first_q, first_d, retry_q, retry_d;
    logic [4:0]     adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic           we_q, we_d, stb_q, stb_d;
    logic [3:0]     sel_q, sel_d;
    logic [7:0]     byte_q, byte_d, rx_q, rx_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]    err_q, err_d;
    logic [7:0]     rd_byte, wr_byte;
    logic           ack_ok, poll_ok;

`ifdef UART_BIST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] pcnt_q, pcnt_d;
    logic          tmo_q, tmo_d;
    logic          in_poll;
`endif

    function automatic logic [7:0] next_pat(input logic [7:0] b);
        if (PATTERN == 1) return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
        return b + 8'd1;
    endfunction

    // The first stb cycle never accepts an ack, so every access spans at least two stb cycles.
    assign ack_ok  = stb_q & ~first_q & wb_ack_i;
    assign rd_byte = 8'(wb_dat_i >> {adr_q[1:0], 3'b000});
    assign poll_ok = ack_ok & (((state_q == ST_POLL_THRE) & rd_byte[5]) |
                               ((state_q == ST_POLL_DR) & rd_byte[0]));

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        retry_d = 1'b0;
        byte_d  = byte_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
`ifdef UART_BIST_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_LCR_HI;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
                err_d   = 16'd0;
                cnt_d   = '0;
                byte_d  = FIRST_BYTE;
`ifdef UART_BIST_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            ST_LCR_HI: if (ack_ok) begin state_d = ST_GAP; ret_d = ST_DL1; end
            ST_DL1:    if (ack_ok) begin state_d = ST_GAP; ret_d = ST_DL2; end
            ST_DL2:    if (ack_ok) begin state_d = ST_GAP; ret_d = ST_LCR_LO; end
            ST_LCR_LO: if (ack_ok) begin state_d = ST_GAP; ret_d = ST_FCR; end
            ST_FCR:    if (ack_ok) begin state_d = ST_GAP; ret_d = ST_MCR; end
            ST_MCR:    if (ack_ok) begin state_d = ST_GAP; ret_d = ST_POLL_THRE; end
            ST_POLL_THRE, ST_POLL_DR: if (ack_ok) begin
                state_d = ST_GAP;
                if (poll_ok) begin
                    ret_d = (state_q == ST_POLL_THRE) ? ST_WR_THR : ST_RD_RBR;
                end else begin
                    ret_d   = state_q;
                    retry_d = 1'b1;
                end
            end
            ST_WR_THR: if (ack_ok) begin state_d = ST_GAP; ret_d = ST_POLL_DR; end
            ST_RD_RBR: if (ack_ok) begin state_d = ST_CHECK; rx_d = rd_byte; end
            ST_CHECK: begin
                if (rx_q != byte_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                byte_d  = next_pat(byte_q);
                cnt_d   = cnt_q + BCW'(1);
                state_d = (cnt_q == BCW'(NUM_BYTES - 1)) ? ST_RESTORE : ST_POLL_THRE;
            end
            ST_RESTORE: if (ack_ok) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
`ifdef UART_BIST_TIMEOUT_EN
                pass_d  = (err_q == 16'd0) && !tmo_q;
`else
                pass_d  = (err_q == 16'd0);
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            ST_GAP:  begin
                state_d = ret_q;
                retry_d = retry_q;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_BIST_TIMEOUT_EN
        // Retry gaps count toward the poll budget; any other state rearms it.
        in_poll = (state_q == ST_POLL_THRE) || (state_q == ST_POLL_DR) || (state_q == ST_GAP && retry_q);
        pcnt_d  = in_poll ? pcnt_q + TW'(1) : '0;
        if (in_poll && pcnt_q == TW'(TIMEOUT_CYC - 1) && !poll_ok) begin
            state_d = ST_GAP;
            ret_d   = ST_RESTORE;
            retry_d = 1'b0;
            tmo_d   = 1'b1;
        end
`endif

        // Bus fields are decoded from the next state so they launch with stb on entry.
        stb_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = 5'd0;
        wr_byte = 8'h00;
        case (state_d)
            ST_LCR_HI:  begin adr_d = 5'd3; wr_byte = LCR_CFG | 8'h80; end
            ST_DL1:     begin adr_d = 5'd0; wr_byte = DIVISOR[7:0]; end
            ST_DL2:     begin adr_d = 5'd1; wr_byte = DIVISOR[15:8]; end
            ST_LCR_LO:  begin adr_d = 5'd3; wr_byte = LCR_CFG; end
            ST_FCR:     begin adr_d = 5'd2; wr_byte = 8'h07; end
            ST_MCR:     begin adr_d = 5'd4; wr_byte = 8'h10; end
            ST_WR_THR:  begin adr_d = 5'd0; wr_byte = byte_q; end
            ST_RESTORE: begin adr_d = 5'd4; wr_byte = 8'h00; end
            ST_POLL_THRE, ST_POLL_DR: begin adr_d = 5'd5; we_d = 1'b0; end
            ST_RD_RBR:  begin adr_d = 5'd0; we_d = 1'b0; end
            default: begin stb_d = 1'b0; we_d = 1'b0; end
        endcase
        dat_d   = we_d ? ({24'h0, wr_byte} << {adr_d[1:0], 3'b000}) : 32'h0;
        sel_d   = stb_d ? (4'b0001 << adr_d[1:0]) : 4'b0000;
        first_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            first_q <= 1'b0;
            retry_q <= 1'b0;
            adr_q   <= 5'd0;
            dat_q   <= 32'h0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            sel_q   <= 4'b0;
            byte_q  <= 8'h00;
            rx_q    <= 8'h00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'd0;
`ifdef UART_BIST_TIMEOUT_EN
            pcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            first_q <= first_d;
            retry_q <= retry_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            sel_q   <= sel_d;
            byte_q  <= byte_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef UART_BIST_TIMEOUT_EN
            pcnt_q  <= pcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = stb_q;
    assign wb_sel_o  = sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;
    assign last_rx_o = rx_q;
`ifdef UART_BIST_TIMEOUT_EN
    assign timeout_o = tmo_q;
`endif
endmodule

// File: tb/tb_uart_wb_bist.sv
// tb/tb_uart_wb_bist.sv - randomized self-check of uart_wb_bist against a loopback UART model
module tb_uart_wb_bist;
    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic [4:0]  adr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        we [2], stb [2], cyc [2], ack [2];
    logic [3:0]  sel [2];
    logic        busy [2], done [2], pass [2];
    logic [15:0] err [2];
    logic [7:0]  lrx [2];
`ifdef UART_BIST_TIMEOUT_EN
    logic        tmo [2];
`endif

    always #5 clk = ~clk;

    uart_wb_bist #(.TIMEOUT_CYC(100)) dut0 (
        .clk(clk), .wb_rst_i(rst), .start_i(start[0]),
        .wb_adr_o(adr[0]), .wb_dat_o(wdat[0]), .wb_dat_i(rdat[0]),
        .wb_we_o(we[0]), .wb_stb_o(stb[0]), .wb_cyc_o(cyc[0]), .wb_sel_o(sel[0]),
        .wb_ack_i(ack[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
        .err_cnt_o(err[0]), .last_rx_o(lrx[0])
`ifdef UART_BIST_TIMEOUT_EN
        , .timeout_o(tmo[0])
`endif
    );

    uart_wb_bist #(.NUM_BYTES(5), .PATTERN(1), .SEED(8'h00), .TIMEOUT_CYC(100)) dut1 (
        .clk(clk), .wb_rst_i(rst), .start_i(start[1]),
        .wb_adr_o(adr[1]), .wb_dat_o(wdat[1]), .wb_dat_i(rdat[1]),
        .wb_we_o(we[1]), .wb_stb_o(stb[1]), .wb_cyc_o(cyc[1]), .wb_sel_o(sel[1]),
        .wb_ack_i(ack[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
        .err_cnt_o(err[1]), .last_rx_o(lrx[1])
`ifdef UART_BIST_TIMEOUT_EN
        , .timeout_o(tmo[1])
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural loopback UART serving whichever instance is active.
    int          act = 0;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [7:0]  lcr = 8'h00, mcr = 8'h00, dll = 8'h00, dlm = 8'h00;
    logic [7:0]  rxq [$];
    logic [13:0] wlog [$];
    int          dr_dly = 0, s_wait = 0, rd_idx = 0, corrupt_idx = -1, done_cnt = 0;
    logic [7:0]  corrupt_val = 8'h00;
    bit          stuck = 1'b0;
    logic        m_cyc, m_stb, m_we;
    logic [4:0]  m_adr;
    logic [31:0] m_wdat;
    logic [3:0]  m_sel;

    always_comb begin
        m_cyc  = cyc[act];
        m_stb  = stb[act];
        m_we   = we[act];
        m_adr  = adr[act];
        m_wdat = wdat[act];
        m_sel  = sel[act];
    end

    assign ack[0]  = (act == 0) && s_ack;
    assign ack[1]  = (act == 1) && s_ack;
    assign rdat[0] = (act == 0) ? s_rdata : 32'h0;
    assign rdat[1] = (act == 1) ? s_rdata : 32'h0;

    always @(posedge clk) begin
        logic [7:0]  b;
        logic [31:0] r;
        int          lane;
        if (done[act]) done_cnt++;
        if (rst) begin
            s_ack <= 1'b0;
            s_wait = 0;
        end else begin
            if (dr_dly > 0) dr_dly--;
            if (s_ack) s_ack <= 1'b0;
            else if (m_cyc && m_stb) begin
                if (s_wait > 0) s_wait--;
                else begin
                    lane = int'(m_adr[1:0]);
                    s_ack <= 1'b1;
                    s_wait = $urandom_range(0, 2);
                    check_eq("sel_lane", m_sel, 4'b0001 << lane);
                    if (m_we) begin
                        b = 8'(m_wdat >> (lane * 8));
                        wlog.push_back({act[0], m_adr, b});
                        case (m_adr)
                            5'd0: if (lcr[7]) dll = b;
                                  else if (mcr[4]) begin rxq.push_back(b); dr_dly = $urandom_range(0, 6); end
                            5'd1: if (lcr[7]) dlm = b;
                            5'd2: if (b[1]) rxq.delete();
                            5'd3: lcr = b;
                            5'd4: mcr = b;
                            default: ;
                        endcase
                    end else begin
                        if (m_adr == 5'd5)
                            b = stuck ? 8'h20 : {2'b00, ($urandom_range(0, 3) != 0), 4'b0000,
                                                 (rxq.size() != 0 && dr_dly == 0)};
                        else if (m_adr == 5'd0) begin
                            b = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
                            if (rd_idx == corrupt_idx) b = corrupt_val;
                            rd_idx++;
                        end else b = 8'h00;
                        r = $urandom;
                        r[lane*8 +: 8] = b;
                        s_rdata <= r;
                    end
                end
            end
        end
    end

    task automatic run_bist(input int g, input int cidx, input logic [7:0] cval, input bit poke, input bit stk);
        int         nb, cyc_n, e_err, n_thr;
        logic [7:0] eb [$];
        logic [7:0] v, rxv, e_last;
        logic [13:0] ew [$];
        logic       e_pass;
        act = g; corrupt_idx = cidx; corrupt_val = cval; stuck = stk;
        rd_idx = 0; wlog.delete(); done_cnt = 0;
        nb = (g == 1) ? 5 : 4;
        v  = (g == 1) ? 8'h01 : 8'h81;
        for (int i = 0; i < nb; i++) begin
            eb.push_back(v);
            v = (g == 1) ? {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]} : 8'((int'(v) + 1) % 256);
        end
        e_err = 0; e_last = 8'h00;
        for (int i = 0; i < nb; i++) begin
            rxv = (i == cidx) ? cval : eb[i];
            if (rxv != eb[i]) e_err++;
            e_last = rxv;
        end
        e_pass = (e_err == 0) && !stk;
        if (stk) e_err = 0;
        n_thr = stk ? 1 : nb;
        ew = '{{1'(g), 5'd3, 8'h9B}, {1'(g), 5'd0, 8'h02}, {1'(g), 5'd1, 8'h00},
               {1'(g), 5'd3, 8'h1B}, {1'(g), 5'd2, 8'h07}, {1'(g), 5'd4, 8'h10}};
        for (int i = 0; i < n_thr; i++) ew.push_back({1'(g), 5'd0, eb[i]});
        ew.push_back({1'(g), 5'd4, 8'h00});

        @(negedge clk) start[g] = 1'b1;
        @(negedge clk) start[g] = 1'b0;
        check_eq("start_launch", {busy[g], stb[g], cyc[g], adr[g]}, {3'b111, 5'd3});
        cyc_n = 0;
        while (!done[g] && cyc_n < 20000) begin
            @(negedge clk);
            cyc_n++;
            if (poke && cyc_n == 40) start[g] = 1'b1;
            if (poke && cyc_n == 41) start[g] = 1'b0;
        end
        check_eq("done_seen", cyc_n < 20000, 1);
        check_eq("end_busy_pass", {busy[g], pass[g]}, {1'b0, e_pass});
        check_eq("err_cnt", err[g], e_err);
        if (!stk) check_eq("last_rx", lrx[g], e_last);
`ifdef UART_BIST_TIMEOUT_EN
        check_eq("timeout", tmo[g], stk);
`endif
        repeat (3) @(negedge clk);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("idle_after", {busy[g], done[g], stb[g]}, 0);
        check_eq("pass_held", pass[g], e_pass);
        check_eq("wr_count", wlog.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wlog.size(); i++) check_eq($sformatf("wr%0d", i), wlog[i], ew[i]);
        check_eq("mcr_final", mcr, 8'h00);
    endtask

    initial begin
        int cyc_n;
        rst = 1'b1; start[0] = 1'b1; start[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_eq("rst_bus", {adr[g], sel[g], we[g], stb[g], cyc[g], wdat[g]}, 0);
            check_eq("rst_status", {busy[g], done[g], pass[g], err[g], lrx[g]}, 0);
`ifdef UART_BIST_TIMEOUT_EN
            check_eq("rst_timeout", tmo[g], 0);
`endif
        end
        rst = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("no_start_in_rst", {busy[0], busy[1], stb[0], stb[1]}, 0);

        run_bist(0, -1, 8'h00, 1'b0, 1'b0);
        run_bist(0, 1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) run_bist(0, $urandom_range(0, 3), 8'($urandom), k == 0, 1'b0);
        run_bist(1, -1, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) run_bist(1, $urandom_range(0, 4), 8'($urandom), 1'b0, 1'b0);

        act = 0; stuck = 1'b0; corrupt_idx = -1; wlog.delete(); rd_idx = 0;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        cyc_n = 0;
        while (!(stb[0] && !we[0] && adr[0] == 5'd5 && wlog.size() >= 7) && cyc_n < 2000) begin
            @(negedge clk);
            cyc_n++;
        end
        check_eq("reach_poll_dr", cyc_n < 2000, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_access", {cyc[0], stb[0], busy[0]}, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_bist(0, -1, 8'h00, 1'b0, 1'b0);

`ifdef UART_BIST_TIMEOUT_EN
        run_bist(0, -1, 8'h00, 1'b0, 1'b1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
